store_addr_burst_issuer: RTL and testbench

Consumes store-address requests from the store-address prefetch FIFO and turns each request into one or more DDR write-burst commands. Each burst is capped at a maximum length and never crosses an aligned boundary. It sits directly downstream of the FIFO's read side (rd_data / rd_vld / rd_en) and upstream of the DDR write-channel arbiter's command port.

---
 rtl/store_addr_burst_issuer.sv | 189 ++++++++++++++++++
 tb/tb_store_addr_burst_issuer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_addr_burst_issuer.sv
// Purpose : splits {len, addr} store-address requests popped from an FWFT FIFO into
//           DDR write-burst commands, each capped at MAX_BURST beats and never
//           crossing a 2^BND_W-beat aligned boundary (the address space wraps at 2^ADDR_W).
// Latency : pop at edge N -> first command sampled at edge N+2; one burst per 2 cycles at best.
// Backpressure: cmd_* is held stable until cmd_ready; no pop while a request is in flight,
//           so stalls propagate upstream through the FIFO's valid.
// Ports   : clk, rst_n (sync, active-low)
//           addr_data/addr_vld/addr_rd_en : FIFO read side, pop = addr_vld & addr_rd_en
//           cmd_valid/cmd_ready/cmd_addr/cmd_len/cmd_last : burst command (cmd_len = beats-1)
//           busy : request in progress;  zero_len_err : one-cycle pulse after a len==0 pop
module store_addr_burst_issuer #(
  parameter int ADDR_W    = 28,
  parameter int LEN_W     = 16,
  parameter int BURST_W   = 8,
  parameter int MAX_BURST = 64,
  parameter int BND_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LEN_W+ADDR_W-1:0] addr_data,
  input  logic                    addr_vld,
  output logic                    addr_rd_en,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [ADDR_W-1:0]       cmd_addr,
  output logic [BURST_W-1:0]      cmd_len,
  output logic                    cmd_last,
  output logic                    busy,
  output logic                    zero_len_err
);

  // Common width for the three-way minimum: wide enough for rem, to_bnd and MAX_BURST.
  localparam int CW0 = (LEN_W > BND_W + 1) ? LEN_W : BND_W + 1;
  localparam int CW  = (CW0 > BURST_W + 1) ? CW0 : BURST_W + 1;

  localparam logic [BND_W:0] BND_SPAN  = {1'b1, {BND_W{1'b0}}};
  localparam logic [CW-1:0]  MAX_BLEN  = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0]  cur_addr_q;
  logic [LEN_W-1:0]   rem_q;
  logic [BURST_W:0]   blen_q;

  logic               cmd_valid_q;
  logic [ADDR_W-1:0]  cmd_addr_q;
  logic [BURST_W-1:0] cmd_len_q;
  logic               cmd_last_q;
  logic               zero_len_err_q;

  // FSM strobes
  logic               load_req;
  logic               zerr_set;
  logic               calc_en;
  logic               hs;

  // Request fields from the FIFO head
  logic [ADDR_W-1:0]  req_addr;
  logic [LEN_W-1:0]   req_len;

  // Burst sizing datapath
  logic [BND_W:0]     to_bnd;
  logic [CW-1:0]      rem_w;
  logic [CW-1:0]      bnd_w;
  logic [CW-1:0]      min_a;
  logic [CW-1:0]      blen_w;
  logic [BURST_W:0]   blen_n;
  logic [BURST_W:0]   blen_m1;
  logic               last_n;

  assign req_addr = addr_data[ADDR_W-1:0];
  assign req_len  = addr_data[ADDR_W+LEN_W-1:ADDR_W];

  // Beats left before the next aligned boundary; a zero offset yields the full span,
  // which is why this is one bit wider than the offset.
  assign to_bnd = BND_SPAN - {1'b0, cur_addr_q[BND_W-1:0]};

  always_comb begin
    rem_w   = CW'(rem_q);
    bnd_w   = CW'(to_bnd);
    min_a   = (rem_w < MAX_BLEN) ? rem_w : MAX_BLEN;
    blen_w  = (min_a < bnd_w) ? min_a : bnd_w;
    // blen is at most 2^BURST_W so it fits BURST_W+1 bits
    blen_n  = blen_w[BURST_W:0];
    blen_m1 = blen_n - {{BURST_W{1'b0}}, 1'b1};
    last_n  = (rem_w == blen_w);
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_rd_en = 1'b0;
    load_req   = 1'b0;
    zerr_set   = 1'b0;
    calc_en    = 1'b0;
    hs         = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Pop request depends on state only, never on addr_vld
        addr_rd_en = 1'b1;
        if (addr_vld) begin
          if (req_len == '0) begin
            zerr_set = 1'b1;
          end else begin
            load_req = 1'b1;
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        calc_en = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (cmd_valid_q && cmd_ready) begin
          hs = 1'b1;
          // cmd_last was registered as (rem == blen), i.e. nothing remains after this burst
          state_d = cmd_last_q ? IDLE : CALC;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request tracking and command registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_addr_q     <= '0;
      rem_q          <= '0;
      blen_q         <= '0;
      cmd_valid_q    <= 1'b0;
      cmd_addr_q     <= '0;
      cmd_len_q      <= '0;
      cmd_last_q     <= 1'b0;
      zero_len_err_q <= 1'b0;
    end else begin
      zero_len_err_q <= zerr_set;

      if (load_req) begin
        cur_addr_q <= req_addr;
        rem_q      <= req_len;
      end

      if (calc_en) begin
        cmd_addr_q  <= cur_addr_q;
        cmd_len_q   <= blen_m1[BURST_W-1:0];
        cmd_last_q  <= last_n;
        cmd_valid_q <= 1'b1;
        blen_q      <= blen_n;
      end

      if (hs) begin
        // Address advance wraps naturally at 2^ADDR_W; blen <= rem so rem never underflows
        cur_addr_q  <= cur_addr_q + ADDR_W'(blen_q);
        rem_q       <= rem_q - LEN_W'(blen_q);
        cmd_valid_q <= 1'b0;
      end
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd_addr     = cmd_addr_q;
  assign cmd_len      = cmd_len_q;
  assign cmd_last     = cmd_last_q;
  assign zero_len_err = zero_len_err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_store_addr_burst_issuer.sv
// Purpose : self-checking bench for store_addr_burst_issuer; an FWFT FIFO model feeds
//           requests, expected bursts go to a scoreboard queue at push time and are
//           compared on every command handshake.
// Latency/backpressure: checks pop-to-command latency, inter-burst gap and stall stability.
module tb_store_addr_burst_issuer;

  localparam int ADDR_W  = 28;
  localparam int LEN_W   = 16;
  localparam int BURST_W = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [LEN_W+ADDR_W-1:0] addr_data;
  logic                    addr_vld;
  logic                    addr_rd_en;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [ADDR_W-1:0]       cmd_addr;
  logic [BURST_W-1:0]      cmd_len;
  logic                    cmd_last;
  logic                    busy;
  logic                    zero_len_err;

  always #5 clk = ~clk;

  store_addr_burst_issuer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr_data    (addr_data),
    .addr_vld     (addr_vld),
    .addr_rd_en   (addr_rd_en),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .cmd_last     (cmd_last),
    .busy         (busy),
    .zero_len_err (zero_len_err)
  );

  typedef struct {
    logic [ADDR_W-1:0]  a;
    logic [BURST_W-1:0] l;
    logic               last;
  } exp_t;

  exp_t                    sb[$];
  logic [LEN_W+ADDR_W-1:0] fifo_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_pop_cyc  = 0;
  int prev_pop_cyc  = 0;
  int hs_edge  = 0;
  int zerr_cnt = 0;
  logic popped_zero = 1'b0;
  logic mid_req  = 1'b0;
  logic prev_vld = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input int l, input logic last);
    exp_t e;
    e.a = a;
    e.l = BURST_W'(l);
    e.last = last;
    sb.push_back(e);
  endtask

  task automatic push_entry(input int len, input logic [ADDR_W-1:0] a);
    fifo_q.push_back({LEN_W'(len), a});
  endtask

  // Reference split: min(remaining, 64, beats to the next 256-beat boundary)
  task automatic model_entry(input int len, input logic [ADDR_W-1:0] a0);
    int r;
    int tb_n;
    int b;
    logic [ADDR_W-1:0] a;
    a = a0;
    r = len;
    while (r > 0) begin
      tb_n = 256 - int'(a[7:0]);
      b = (r < 64) ? r : 64;
      if (tb_n < b) b = tb_n;
      push_exp(a, b - 1, (r == b));
      a = a + ADDR_W'(b);
      r = r - b;
    end
    push_entry(len, a0);
  endtask

  always @(posedge clk) cyc++;

  // FWFT FIFO model: pop decision taken from values settled before the edge
  initial begin
    addr_vld  = 1'b0;
    addr_data = '0;
    forever begin
      logic wp;
      @(negedge clk);
      wp = addr_vld && addr_rd_en && rst_n;
      @(posedge clk);
      #1;
      popped_zero = 1'b0;
      if (wp) begin
        popped_zero  = (fifo_q[0][LEN_W+ADDR_W-1:ADDR_W] == '0);
        prev_pop_cyc = last_pop_cyc;
        last_pop_cyc = cyc;
        void'(fifo_q.pop_front());
      end
      addr_vld  = (fifo_q.size() != 0);
      addr_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    end
  end

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      mid_req  = 1'b0;
      prev_vld = 1'b0;
    end else begin
      if (zero_len_err || popped_zero) chk("zero_len_err", zero_len_err, popped_zero);
      if (zero_len_err) zerr_cnt++;
      if (cmd_valid && !prev_vld) begin
        if (mid_req) chk("burst_gap", cyc + 1 - hs_edge, 2);
        else         chk("pop_to_cmd", cyc + 1 - last_pop_cyc, 2);
      end
      if (cmd_valid && cmd_ready) begin
        chk("cmd_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("cmd_addr", cmd_addr, e.a);
          chk("cmd_len", cmd_len, e.l);
          chk("cmd_last", cmd_last, e.last);
        end
        hs_edge = cyc + 1;
        mid_req = !cmd_last;
      end
      prev_vld = cmd_valid;
    end
  end

  task automatic wait_done(input int budget, input logic rnd);
    int n;
    n = 0;
    while (n < budget && !(sb.size() == 0 && fifo_q.size() == 0 && !addr_vld && !busy && !cmd_valid)) begin
      @(posedge clk);
      #1;
      if (rnd) cmd_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("drain_timeout", sb.size(), 0);
    cmd_ready = 1'b1;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_valid) chk("valid_timeout", cmd_valid, 1);
  endtask

  initial begin
    int busy_cnt;
    int z0;
    rst_n     = 1'b0;
    cmd_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", addr_rd_en, 1);
    chk("rst_zerr", zero_len_err, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    chk("rst_cmd_len", cmd_len, 0);
    chk("rst_cmd_last", cmd_last, 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    cmd_ready = 1'b1;

    // Single full burst; busy spans CALC + ISSUE
    push_exp(28'h0000000, 63, 1'b1);
    push_entry(64, 28'h0000000);
    busy_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    chk("busy_cycles", busy_cnt, 2);
    wait_done(100, 1'b0);

    // Boundary split at 0x100
    push_exp(28'h00000F0, 15, 1'b0);
    push_exp(28'h0000100, 23, 1'b1);
    push_entry(40, 28'h00000F0);
    wait_done(100, 1'b0);

    // Length cap split
    push_exp(28'h0000000, 63, 1'b0);
    push_exp(28'h0000040, 63, 1'b0);
    push_exp(28'h0000080, 21, 1'b1);
    push_entry(150, 28'h0000000);
    wait_done(100, 1'b0);

    // Address wrap with a 10-cycle stall on the first burst
    cmd_ready = 1'b0;
    push_exp(28'hFFFFFF8, 7, 1'b0);
    push_exp(28'h0000000, 7, 1'b1);
    push_entry(16, 28'hFFFFFF8);
    wait_valid(20);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", cmd_valid, 1);
      chk("stall_addr", cmd_addr, 28'hFFFFFF8);
      chk("stall_len", cmd_len, 7);
      chk("stall_last", cmd_last, 0);
      chk("stall_rd_en", addr_rd_en, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    wait_done(100, 1'b0);

    // Zero-length entry followed immediately by a single-beat request
    z0 = zerr_cnt;
    push_exp(28'h0000005, 0, 1'b1);
    push_entry(0, 28'h0000123);
    push_entry(1, 28'h0000005);
    wait_done(100, 1'b0);
    chk("zerr_pulses", zerr_cnt - z0, 1);
    chk("pop_after_zero", last_pop_cyc - prev_pop_cyc, 1);

    // Reset while the second burst of a long request is stalled
    cmd_ready = 1'b0;
    push_exp(28'h0000000, 63, 1'b0);
    push_entry(150, 28'h0000000);
    wait_valid(20);
    @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_ready = 1'b0;
    wait_valid(20);
    chk("second_burst_addr", cmd_addr, 28'h0000040);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", cmd_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_en", addr_rd_en, 1);
    sb.delete();
    cmd_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_quiet", cmd_valid, 0);

    // Random requests with random backpressure against the reference split
    for (int k = 0; k < 12; k++) begin
      int len;
      logic [ADDR_W-1:0] a;
      len = (k % 5 == 4) ? 0 : int'($urandom_range(1, 300));
      a   = ADDR_W'($urandom);
      if (k == 3) a = 28'hFFFFF80;
      model_entry(len, a);
    end
    wait_done(4000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
